// File: rtl/denorm_shift.sv
// denorm_shift: two-stage right-shift denormalizer with sticky capture.
// S1 shifts by whole nibbles (4 * upper count bits) and folds the dropped
// bits into a partial sticky; S2 finishes with a 0..3 bit shift. Each stage
// has its own valid bit and ready is derived combinationally back from the
// output, so the pipe sustains one operation per cycle.
module denorm_shift #(
   parameter int WIDTH   = 8,
   parameter int SHIFT_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHIFT_W-1:0] in_shift,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_sticky,
   output logic               out_zero,
   output logic               out_valid,
   input  logic               out_ready
);

   // Stage registers
   logic               s1_valid_reg;
   logic [WIDTH-1:0]   s1_data_reg;
   logic               s1_sticky_reg;
   logic [1:0]         s1_fine_reg;
   logic               s2_valid_reg;
   logic [WIDTH-1:0]   s2_data_reg;
   logic               s2_sticky_reg;
   logic               s2_zero_reg;

   // Next-state values for the data paths
   logic [WIDTH-1:0]   s1_data_next;
   logic               s1_sticky_next;
   logic [WIDTH-1:0]   s2_data_next;
   logic               s2_sticky_next;
   logic               s2_zero_next;

   // Handshake
   logic               s2_ready;
   logic               s1_ready;
   logic               in_fire;
   logic               s1_advance;

   // Coarse shift helpers
   logic [SHIFT_W-1:0] coarse_amt;
   logic               over_range;
   logic [WIDTH-1:0]   coarse_drop;
   logic [WIDTH-1:0]   fine_drop;

   assign s2_ready   = !s2_valid_reg || out_ready;
   assign s1_ready   = !s1_valid_reg || s2_ready;
   assign in_ready   = s1_ready;
   assign in_fire    = in_valid && s1_ready;
   assign s1_advance = s1_valid_reg && s2_ready;

   // Nibble-aligned part of the count; low two bits go to the fine stage.
   assign coarse_amt = {in_shift[SHIFT_W-1:2], 2'b00};
   assign over_range = (int'(in_shift) >= WIDTH);

   // Per-bit "shifted out" masks: bit gi is lost when the shift exceeds gi.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_drop
         assign coarse_drop[gi] = in_data[gi] & (int'(coarse_amt) > gi);
         assign fine_drop[gi]   = s1_data_reg[gi] & (int'(s1_fine_reg) > gi);
      end
   endgenerate

   // S1 datapath: coarse shift, with the whole operand becoming sticky when over range
   always_comb begin
      s1_data_next   = in_data >> coarse_amt;
      s1_sticky_next = |coarse_drop;
      if (over_range) begin
         s1_data_next   = '0;
         s1_sticky_next = |in_data;
      end
   end

   // S2 datapath: fine shift and final sticky / zero flags
   always_comb begin
      s2_data_next   = s1_data_reg >> s1_fine_reg;
      s2_sticky_next = s1_sticky_reg | (|fine_drop);
      s2_zero_next   = (s2_data_next == '0);
   end

   // S1 registers: load on input transfer, drain when passing to S2 with nothing new
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg  <= 1'b0;
         s1_data_reg   <= '0;
         s1_sticky_reg <= 1'b0;
         s1_fine_reg   <= '0;
      end else if (in_fire) begin
         s1_valid_reg  <= 1'b1;
         s1_data_reg   <= s1_data_next;
         s1_sticky_reg <= s1_sticky_next;
         s1_fine_reg   <= in_shift[1:0];
      end else if (s2_ready) begin
         s1_valid_reg  <= 1'b0;
      end
   end

   // S2 registers: load from S1 when it advances, drain when consumed with nothing behind
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_reg  <= 1'b0;
         s2_data_reg   <= '0;
         s2_sticky_reg <= 1'b0;
         s2_zero_reg   <= 1'b0;
      end else if (s1_advance) begin
         s2_valid_reg  <= 1'b1;
         s2_data_reg   <= s2_data_next;
         s2_sticky_reg <= s2_sticky_next;
         s2_zero_reg   <= s2_zero_next;
      end else if (out_ready) begin
         s2_valid_reg  <= 1'b0;
      end
   end

   assign out_valid  = s2_valid_reg;
   assign out_data   = s2_data_reg;
   assign out_sticky = s2_sticky_reg;
   assign out_zero   = s2_zero_reg;

endmodule

// File: tb/tb_denorm_shift.sv
// Scoreboard bench for denorm_shift: accepted inputs push a reference result,
// a negedge monitor pops and compares on every output transfer and checks
// that held outputs do not move.
module tb_denorm_shift;

   localparam int WIDTH   = 8;
   localparam int SHIFT_W = 4;

   logic               clk;
   logic               rst_n;
   logic [WIDTH-1:0]   in_data;
   logic [SHIFT_W-1:0] in_shift;
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   out_data;
   logic               out_sticky;
   logic               out_zero;
   logic               out_valid;
   logic               out_ready;

   denorm_shift #(.WIDTH(WIDTH), .SHIFT_W(SHIFT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_data    (in_data),
      .in_shift   (in_shift),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_sticky (out_sticky),
      .out_zero   (out_zero),
      .out_valid  (out_valid),
      .out_ready  (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [WIDTH-1:0] d;
      logic             st;
      logic             z;
      int               c;
   } exp_t;

   exp_t             sb[$];
   int               errors    = 0;
   int               checks    = 0;
   int               cyc       = 0;
   int               out_count = 0;
   bit               check_lat = 0;
   logic [WIDTH-1:0] last_data;
   logic             last_sticky;
   logic             last_zero;
   bit               held = 0;
   logic [WIDTH-1:0] held_data;
   logic             held_sticky;
   logic             held_zero;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
   endtask

   // Reference: plain arithmetic on the definition d >> s with a sticky remainder.
   function automatic exp_t model(input logic [WIDTH-1:0] d, input int s, input int c);
      exp_t e;
      int   dv;
      int   p;
      dv = int'(d);
      if (s >= WIDTH) begin
         e.d  = '0;
         e.st = (dv != 0);
      end else begin
         p    = 1 << s;
         e.d  = WIDTH'(dv / p);
         e.st = ((dv % p) != 0);
      end
      e.z = (e.d == '0);
      e.c = c;
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: hold check, output compare, then record newly accepted input.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
         held = 0;
      end else begin
         if (held) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), int'(held_data));
            chk("hold_sticky", int'(out_sticky), int'(held_sticky));
            chk("hold_zero", int'(out_zero), int'(held_zero));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_output", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("sb_data", int'(out_data), int'(e.d));
               chk("sb_sticky", int'(out_sticky), int'(e.st));
               chk("sb_zero", int'(out_zero), int'(e.z));
               if (check_lat) chk("latency", cyc - e.c, 2);
            end
            out_count++;
            last_data   = out_data;
            last_sticky = out_sticky;
            last_zero   = out_zero;
         end
         if (in_valid && in_ready) sb.push_back(model(in_data, int'(in_shift), cyc));
         held        = out_valid && !out_ready;
         held_data   = out_data;
         held_sticky = out_sticky;
         held_zero   = out_zero;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one operation, wait for its result, compare against table constants.
   task automatic send_check(input string nm, input logic [WIDTH-1:0] d, input logic [SHIFT_W-1:0] s,
                             input logic [WIDTH-1:0] ed, input logic es, input logic ez);
      int base;
      int t;
      base     = out_count;
      in_valid = 1'b1;
      in_data  = d;
      in_shift = s;
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      step();
      in_valid = 1'b0;
      t = 0;
      while (out_count == base && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (out_count == base) begin
         timeout(nm);
      end else begin
         chk({nm, "_data"}, int'(last_data), int'(ed));
         chk({nm, "_sticky"}, int'(last_sticky), int'(es));
         chk({nm, "_zero"}, int'(last_zero), int'(ez));
      end
      step();
   endtask

   initial begin
      logic [WIDTH-1:0]   bp_data [4];
      logic [SHIFT_W-1:0] bp_shift[4];
      int idx;
      int base;
      int run;
      int best;
      int rdy_cnt;
      bit fire;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_shift  = '0;
      out_ready = 1'b1;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_sticky", int'(out_sticky), 0);
      chk("rst_out_zero", int'(out_zero), 0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      step();

      // Basic and over-range shifts
      check_lat = 1;
      send_check("b0_s3", 8'hB0, 4'd3, 8'h16, 1'b0, 1'b0);
      send_check("ff_s4", 8'hFF, 4'd4, 8'h0F, 1'b1, 1'b0);
      send_check("5a_s0", 8'h5A, 4'd0, 8'h5A, 1'b0, 1'b0);
      send_check("81_s8", 8'h81, 4'd8, 8'h00, 1'b1, 1'b1);
      send_check("81_s15", 8'h81, 4'd15, 8'h00, 1'b1, 1'b1);
      send_check("00_s15", 8'h00, 4'd15, 8'h00, 1'b0, 1'b1);

      // Streaming: 16 back-to-back operations
      run = 0;
      best = 0;
      rdy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (i < 16) begin
            in_valid = 1'b1;
            in_data  = 8'hA5;
            in_shift = SHIFT_W'(i);
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (i < 16 && in_ready) rdy_cnt++;
         if (out_valid) begin
            run++;
            if (run > best) best = run;
         end else begin
            run = 0;
         end
         step();
      end
      chk("stream_in_ready", rdy_cnt, 16);
      chk("stream_out_run", best, 16);
      check_lat = 0;

      // Backpressure: 6 stalled cycles, 4 items offered
      bp_data  = '{8'h96, 8'h3C, 8'hF1, 8'h7E};
      bp_shift = '{4'd1, 4'd5, 4'd2, 4'd9};
      base = out_count;
      out_ready = 1'b0;
      idx = 0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 1'b1;
         in_data  = bp_data[idx];
         in_shift = bp_shift[idx];
         @(negedge clk);
         fire = in_ready;
         step();
         if (fire) idx++;
      end
      chk("bp_accepted", idx, 2);
      @(negedge clk);
      chk("bp_in_ready_low", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      step();
      out_ready = 1'b1;
      for (int t = 0; t < 20 && idx < 4; t++) begin
         in_valid = 1'b1;
         in_data  = bp_data[idx];
         in_shift = bp_shift[idx];
         @(negedge clk);
         fire = in_ready;
         step();
         if (fire) idx++;
      end
      in_valid = 1'b0;
      repeat (4) step();
      chk("bp_all_out", out_count - base, 4);

      // Reset mid-flight
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h44;
      in_shift  = 4'd2;
      step();
      in_data   = 8'h22;
      in_shift  = 4'd1;
      step();
      in_valid  = 1'b0;
      rst_n     = 1'b0;
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_in_ready", int'(in_ready), 1);
      run = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (out_valid) run++;
      end
      chk("midrst_no_output", run, 0);
      step();
      check_lat = 1;
      send_check("80_s7", 8'h80, 4'd7, 8'h01, 1'b0, 1'b0);
      check_lat = 0;

      // Random traffic
      for (int i = 0; i < 10000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = WIDTH'($urandom);
         in_shift  = SHIFT_W'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (5) step();
      chk("drain_empty", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
